procyon_lsu_dc_arbiter: RTL and testbench

//  Arbitrates the single LSU address/D$ port between four requesters: MHQ fill, SQ retire, LQ replay, new FU op.

---
 rtl/procyon_lsu_dc_arbiter_if.sv | 32 +++
 rtl/procyon_lsu_dc_arbiter.sv | 103 ++++++++++
 tb/tb_procyon_lsu_dc_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/procyon_lsu_dc_arbiter_if.sv
// Request/back-pressure bundle between the LSU requesters and the D$ port arbiter.
// The arbiter uses the slave modport; the requester side (or a bench) uses master.
interface procyon_lsu_dc_arbiter_if;
    logic       i_flush;
    logic       i_mhq_fill_en;
    logic       i_sq_retire_en;
    logic       o_sq_retire_stall;
    logic       i_lq_replay_en;
    logic       o_lq_replay_stall;
    logic       i_fu_valid;
    logic       i_fu_is_store;
    logic       i_lq_full;
    logic       i_sq_full;
    logic       o_fu_stall;
    logic       o_valid;
    logic [1:0] o_sel;
    logic [3:0] o_grant;

    modport slave (
        input  i_flush, i_mhq_fill_en, i_sq_retire_en, i_lq_replay_en,
               i_fu_valid, i_fu_is_store, i_lq_full, i_sq_full,
        output o_sq_retire_stall, o_lq_replay_stall, o_fu_stall,
               o_valid, o_sel, o_grant
    );

    modport master (
        output i_flush, i_mhq_fill_en, i_sq_retire_en, i_lq_replay_en,
               i_fu_valid, i_fu_is_store, i_lq_full, i_sq_full,
        input  o_sq_retire_stall, o_lq_replay_stall, o_fu_stall,
               o_valid, o_sel, o_grant
    );
endinterface

// File: rtl/procyon_lsu_dc_arbiter.sv
// Single-port LSU/D$ arbiter: fill > retire > replay > fu, with a registered one-hot grant.
// Define PCYN_LSU_ARB_AGING_EN to let starved replay/fu requests overtake SQ retires.
module procyon_lsu_dc_arbiter #(
    parameter int OPTN_STARVE_LIMIT = 8
) (
    input  logic                          clk,
    input  logic                          n_rst,
    procyon_lsu_dc_arbiter_if.slave       arb
);

    logic       elig_fill, elig_retire, elig_rp, elig_fu;
    logic       win_fill, win_retire, win_rp, win_fu;
    logic       promote_rp, promote_fu;
    logic       valid_d, valid_q;
    logic [1:0] sel_d, sel_q;
    logic [3:0] grant_d, grant_q;

    always_comb begin
        elig_fill   = arb.i_mhq_fill_en;
        elig_retire = arb.i_sq_retire_en;
        elig_rp     = arb.i_lq_replay_en & ~arb.i_flush;
        elig_fu     = arb.i_fu_valid & ~arb.i_flush &
                      ~(arb.i_fu_is_store ? arb.i_sq_full : arb.i_lq_full);
    end

`ifdef PCYN_LSU_ARB_AGING_EN
    localparam int                AGE_W   = $clog2(OPTN_STARVE_LIMIT + 1);
    localparam logic [AGE_W-1:0]  AGE_MAX = AGE_W'(OPTN_STARVE_LIMIT);

    logic [AGE_W-1:0] fu_age_d, fu_age_q, rp_age_d, rp_age_q;

    assign promote_rp = elig_rp & (rp_age_q == AGE_MAX);
    assign promote_fu = elig_fu & (fu_age_q == AGE_MAX);

    // Waiting-and-losing counts up; any other cycle (grant, drop, flush) restarts the wait.
    always_comb begin
        rp_age_d = '0;
        fu_age_d = '0;
        if (elig_rp && !win_rp)
            rp_age_d = (rp_age_q == AGE_MAX) ? AGE_MAX : rp_age_q + 1'b1;
        if (elig_fu && !win_fu)
            fu_age_d = (fu_age_q == AGE_MAX) ? AGE_MAX : fu_age_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            rp_age_q <= '0;
            fu_age_q <= '0;
        end else begin
            rp_age_q <= rp_age_d;
            fu_age_q <= fu_age_d;
        end
    end
`else
    logic unused_starve_limit;

    assign unused_starve_limit = ^OPTN_STARVE_LIMIT;
    assign promote_rp          = 1'b0;
    assign promote_fu          = 1'b0;
`endif

    always_comb begin
        win_fill   = 1'b0;
        win_retire = 1'b0;
        win_rp     = 1'b0;
        win_fu     = 1'b0;
        if (elig_fill)        win_fill   = 1'b1;
        else if (promote_rp)  win_rp     = 1'b1;
        else if (promote_fu)  win_fu     = 1'b1;
        else if (elig_retire) win_retire = 1'b1;
        else if (elig_rp)     win_rp     = 1'b1;
        else if (elig_fu)     win_fu     = 1'b1;

        arb.o_sq_retire_stall = arb.i_sq_retire_en & ~win_retire;
        arb.o_lq_replay_stall = arb.i_lq_replay_en & ~win_rp;
        arb.o_fu_stall        = arb.i_fu_valid & ~win_fu;

        grant_d = {win_fill, win_retire, win_rp, win_fu};
        valid_d = |grant_d;
        sel_d   = sel_q;
        if (win_fill)        sel_d = 2'd3;
        else if (win_retire) sel_d = 2'd2;
        else if (win_rp)     sel_d = 2'd1;
        else if (win_fu)     sel_d = 2'd0;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            valid_q <= 1'b0;
            sel_q   <= 2'd0;
            grant_q <= 4'd0;
        end else begin
            valid_q <= valid_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
        end
    end

    assign arb.o_valid = valid_q;
    assign arb.o_sel   = sel_q;
    assign arb.o_grant = grant_q;

endmodule

// File: tb/tb_procyon_lsu_dc_arbiter.sv
// Directed + random bench for procyon_lsu_dc_arbiter against a priority-list reference model.
module tb_procyon_lsu_dc_arbiter;
    localparam int LIMIT = 8;
`ifdef PCYN_LSU_ARB_AGING_EN
    localparam bit AGING = 1'b1;
`else
    localparam bit AGING = 1'b0;
`endif

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    procyon_lsu_dc_arbiter_if arb ();

    procyon_lsu_dc_arbiter #(.OPTN_STARVE_LIMIT(LIMIT)) u_dut (
        .clk   (clk),
        .n_rst (n_rst),
        .arb   (arb)
    );

    int tests = 0;
    int fails = 0;

    bit       m_valid = 1'b0;
    bit [1:0] m_sel   = 2'd0;
    bit [3:0] m_grant = 4'd0;
    int       m_fu_age = 0;
    int       m_rp_age = 0;
    int       last_win;
    bit       last_sq_stall, last_lq_stall, last_fu_stall;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Winner index 0 FU, 1 REPLAY, 2 RETIRE, 3 FILL; -1 when nobody is eligible.
    function automatic int model_win();
        bit e_rp, e_fu;
        e_rp = arb.i_lq_replay_en && !arb.i_flush;
        e_fu = arb.i_fu_valid && !arb.i_flush &&
               !(arb.i_fu_is_store ? arb.i_sq_full : arb.i_lq_full);
        if (arb.i_mhq_fill_en)              return 3;
        if (AGING && e_rp && m_rp_age >= LIMIT) return 1;
        if (AGING && e_fu && m_fu_age >= LIMIT) return 0;
        if (arb.i_sq_retire_en)             return 2;
        if (e_rp)                           return 1;
        if (e_fu)                           return 0;
        return -1;
    endfunction

    task automatic step(input bit rst_b, input bit flush, input bit fill, input bit ret,
                        input bit rp, input bit fuv, input bit fust, input bit lqf,
                        input bit sqf, input string tag);
        int  w;
        bit  e_rp, e_fu;
        n_rst              = rst_b;
        arb.i_flush        = flush;
        arb.i_mhq_fill_en  = fill;
        arb.i_sq_retire_en = ret;
        arb.i_lq_replay_en = rp;
        arb.i_fu_valid     = fuv;
        arb.i_fu_is_store  = fust;
        arb.i_lq_full      = lqf;
        arb.i_sq_full      = sqf;
        #2;
        w = model_win();
        e_rp = rp && !flush;
        e_fu = fuv && !flush && !(fust ? sqf : lqf);
        last_win      = w;
        last_sq_stall = arb.o_sq_retire_stall;
        last_lq_stall = arb.o_lq_replay_stall;
        last_fu_stall = arb.o_fu_stall;
        chk({tag, ":sq_stall"}, {3'b0, arb.o_sq_retire_stall}, {3'b0, ret && (w != 2)});
        chk({tag, ":lq_stall"}, {3'b0, arb.o_lq_replay_stall}, {3'b0, rp && (w != 1)});
        chk({tag, ":fu_stall"}, {3'b0, arb.o_fu_stall},        {3'b0, fuv && (w != 0)});
        @(posedge clk);
        #1;
        if (!rst_b) begin
            m_valid = 1'b0; m_sel = 2'd0; m_grant = 4'd0;
            m_fu_age = 0;   m_rp_age = 0;
        end else begin
            m_rp_age = (e_rp && w != 1) ? ((m_rp_age + 1 > LIMIT) ? LIMIT : m_rp_age + 1) : 0;
            m_fu_age = (e_fu && w != 0) ? ((m_fu_age + 1 > LIMIT) ? LIMIT : m_fu_age + 1) : 0;
            if (w >= 0) begin
                m_valid = 1'b1;
                m_sel   = 2'(w);
                m_grant = 4'(1 << w);
            end else begin
                m_valid = 1'b0;
                m_grant = 4'd0;
            end
        end
        chk({tag, ":valid"}, {3'b0, arb.o_valid}, {3'b0, m_valid});
        chk({tag, ":sel"},   {2'b0, arb.o_sel},   {2'b0, m_sel});
        chk({tag, ":grant"}, arb.o_grant,         m_grant);
    endtask

    initial begin
        n_rst = 1'b0;
        arb.i_flush = 0; arb.i_mhq_fill_en = 0; arb.i_sq_retire_en = 0;
        arb.i_lq_replay_en = 0; arb.i_fu_valid = 0; arb.i_fu_is_store = 0;
        arb.i_lq_full = 0; arb.i_sq_full = 0;
        @(posedge clk);
        #1;

        // Reset held with everything requesting
        step(0, 0, 1, 1, 1, 1, 0, 0, 0, "rst0");
        chk("rst0_grant", arb.o_grant, 4'b0000);
        step(0, 0, 1, 1, 1, 1, 0, 0, 0, "rst1");
        chk("rst1_valid", {3'b0, arb.o_valid}, 4'd0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, "rst_after");
        chk("rst_after_grant", arb.o_grant, 4'b0000);

        // All four requesting: fill wins
        step(1, 0, 1, 1, 1, 1, 0, 0, 0, "all4");
        chk("all4_sel", {2'b0, arb.o_sel}, 4'd3);
        chk("all4_grant", arb.o_grant, 4'b1000);
        chk("all4_stalls", {1'b0, last_sq_stall, last_lq_stall, last_fu_stall}, 4'b0111);

        // Retire, then replay, then fu
        step(1, 0, 0, 1, 1, 1, 0, 0, 0, "ret");
        chk("ret_grant", arb.o_grant, 4'b0100);
        step(1, 0, 0, 0, 1, 1, 0, 0, 0, "rp");
        chk("rp_grant", arb.o_grant, 4'b0010);
        step(1, 0, 0, 0, 0, 1, 0, 0, 0, "fu");
        chk("fu_grant", arb.o_grant, 4'b0001);

        // Load blocked by a full LQ, then released
        step(1, 0, 0, 0, 0, 1, 0, 1, 0, "lqfull");
        chk("lqfull_valid", {3'b0, arb.o_valid}, 4'd0);
        chk("lqfull_stall", {3'b0, last_fu_stall}, 4'd1);
        step(1, 0, 0, 0, 0, 1, 1, 1, 1, "sqfull");
        chk("sqfull_valid", {3'b0, arb.o_valid}, 4'd0);
        step(1, 0, 0, 0, 0, 1, 0, 0, 0, "lqfree");
        chk("lqfree_grant", arb.o_grant, 4'b0001);

        // Flush
        step(1, 1, 1, 0, 1, 1, 0, 0, 0, "flush_fill");
        chk("flush_fill_grant", arb.o_grant, 4'b1000);
        step(1, 1, 0, 0, 1, 1, 0, 0, 0, "flush_rpfu");
        chk("flush_rpfu_valid", {3'b0, arb.o_valid}, 4'd0);
        chk("flush_rpfu_stalls", {2'b0, last_lq_stall, last_fu_stall}, 4'b0011);
        step(1, 1, 0, 0, 0, 1, 0, 0, 0, "flush_fu");
        chk("flush_fu_valid", {3'b0, arb.o_valid}, 4'd0);
        step(1, 1, 0, 1, 0, 0, 0, 0, 0, "flush_ret");
        chk("flush_ret_grant", arb.o_grant, 4'b0100);

        // Stream of retires with fu held: starvation vs. aging
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, "idle");
        for (int i = 1; i <= LIMIT; i++) begin
            step(1, 0, 0, 1, 0, 1, 0, 0, 0, "starve");
            chk("starve_grant", arb.o_grant, 4'b0100);
        end
        step(1, 0, 0, 1, 0, 1, 0, 0, 0, "starve_end");
        if (AGING) begin
            chk("aged_grant", arb.o_grant, 4'b0001);
            chk("aged_sq_stall", {3'b0, last_sq_stall}, 4'd1);
        end else begin
            chk("noage_grant", arb.o_grant, 4'b0100);
        end

        // Random traffic, retire-heavy so aging paths get exercised
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 60) != 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 4) == 0), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
